// File: rtl/seq_div_defs_7.sv
// ----------------------------------------------------------------------------
// seq_div_defs_7
// Shared definitions for the stage-7 sequential divider:
//   - FSM state encoding used by seq_divider_7
//   - default operand widths
//   - quotient saturation constants for the default dividend width
// No ports (package).
// ----------------------------------------------------------------------------
package seq_div_defs_7;

   localparam int DEF_DIVIDEND_W = 24;
   localparam int DEF_DIVISOR_W  = 12;

   localparam logic [DEF_DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DEF_DIVIDEND_W-1){1'b1}}};
   localparam logic [DEF_DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DEF_DIVIDEND_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_step_7.sv
// ----------------------------------------------------------------------------
// div_step_7
// One combinational radix-2 non-restoring iteration.
// Ports:
//   rem_i      signed partial remainder from the previous iteration
//   dvs_mag_i  unsigned divisor magnitude
//   bit_i      next dividend bit shifted into the partial remainder
//   rem_o      new signed partial remainder
//   q_o        quotient bit (1 when the new partial remainder is non-negative)
// ----------------------------------------------------------------------------
module div_step_7 #(
   parameter int RW = 14,
   parameter int MW = 13
) (
   input  logic [RW-1:0] rem_i,
   input  logic [MW-1:0] dvs_mag_i,
   input  logic          bit_i,
   output logic [RW-1:0] rem_o,
   output logic          q_o
);

   logic [RW-1:0] shifted;
   logic [RW-1:0] dvs_ext;

   assign shifted = {rem_i[RW-2:0], bit_i};
   assign dvs_ext = {{(RW-MW){1'b0}}, dvs_mag_i};

   // A negative remainder means the previous subtraction overshot; adding the
   // divisor back here folds the restore into this step's trial subtraction.
   assign rem_o = rem_i[RW-1] ? (shifted + dvs_ext) : (shifted - dvs_ext);
   assign q_o   = ~rem_o[RW-1];

endmodule

// File: rtl/seq_divider_7.sv
// ----------------------------------------------------------------------------
// seq_divider_7
// Multi-cycle signed divider for FFT stage 7 (inverse of the stage-7 Booth
// multiplier). One quotient bit per clock, non-restoring core.
// Optional feature macro: SEQ_DIV_ZERO_FLAG_EN (adds the div_zero output).
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          start request, sampled only in IDLE
//   dividend    signed numerator, captured on accept
//   divisor     signed denominator, captured on accept
//   quotient    signed quotient, truncated toward zero
//   remainder   signed remainder, sign follows dividend
//   busy        high from accept until result_rdy
//   div_zero    (SEQ_DIV_ZERO_FLAG_EN only) divide-by-zero / overflow flag
//   result_rdy  one-cycle pulse, quotient/remainder valid
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for en; operands and magnitudes loaded on accept
// CALC    | DIVIDEND_W non-restoring iterations, counter DIVIDEND_W-1..0
// FIX     | remainder restore, sign application, saturation cases
// DONE    | output registers updated, result_rdy pulse raised
// ----------------------------------------------------------------------------
module seq_divider_7
   import seq_div_defs_7::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
`ifdef SEQ_DIV_ZERO_FLAG_EN
   output logic                  div_zero,
`endif
   output logic                  result_rdy
);

   // Partial remainder needs two bits over the divisor width: the magnitude
   // itself is DIVISOR_W+1 bits and the shifted value may double it.
   localparam int RW = DIVISOR_W + 2;
   localparam int CW = $clog2(DIVIDEND_W);

   localparam logic [DIVIDEND_W-1:0] SAT_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
   localparam logic [DIVIDEND_W-1:0] SAT_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

   state_t                  state_q,     state_d;
   logic [CW-1:0]           cnt_q,       cnt_d;
   logic [DIVIDEND_W-1:0]   acc_q,       acc_d;
   logic [RW-1:0]           prem_q,      prem_d;
   logic [DIVISOR_W:0]      dvs_mag_q,   dvs_mag_d;
   logic                    neg_dvd_q,   neg_dvd_d;
   logic                    neg_quo_q,   neg_quo_d;
   logic                    dvs_zero_q,  dvs_zero_d;
   logic                    ovf_q,       ovf_d;
   logic [DIVISOR_W-1:0]    dvd_low_q,   dvd_low_d;
   logic [DIVIDEND_W-1:0]   res_quo_q,   res_quo_d;
   logic [DIVISOR_W-1:0]    res_rem_q,   res_rem_d;
   logic [DIVIDEND_W-1:0]   quotient_q,  quotient_d;
   logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
   logic                    busy_q,      busy_d;
   logic                    rdy_q,       rdy_d;

   logic [DIVIDEND_W-1:0]   dvd_mag;
   logic [DIVISOR_W:0]      dvs_ext;
   logic [DIVISOR_W:0]      dvs_mag;
   logic [RW-1:0]           step_rem;
   logic                    step_q;
   logic [RW-1:0]           rem_fix;
   logic [RW-1:0]           rem_sgn;
   logic [DIVIDEND_W-1:0]   quo_sgn;

   // The most negative dividend negates to 2^(DIVIDEND_W-1), which is still
   // the correct unsigned magnitude in DIVIDEND_W bits.
   assign dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
   assign dvs_ext = {divisor[DIVISOR_W-1], divisor};
   assign dvs_mag = dvs_ext[DIVISOR_W] ? -dvs_ext : dvs_ext;

   div_step_7 #(
      .RW (RW),
      .MW (DIVISOR_W + 1)
   ) u_step (
      .rem_i     (prem_q),
      .dvs_mag_i (dvs_mag_q),
      .bit_i     (acc_q[DIVIDEND_W-1]),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   assign rem_fix = prem_q[RW-1] ? (prem_q + {1'b0, dvs_mag_q}) : prem_q;
   assign rem_sgn = neg_dvd_q ? -rem_fix : rem_fix;
   assign quo_sgn = neg_quo_q ? -acc_q : acc_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      prem_d      = prem_q;
      dvs_mag_d   = dvs_mag_q;
      neg_dvd_d   = neg_dvd_q;
      neg_quo_d   = neg_quo_q;
      dvs_zero_d  = dvs_zero_q;
      ovf_d       = ovf_q;
      dvd_low_d   = dvd_low_q;
      res_quo_d   = res_quo_q;
      res_rem_d   = res_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      rdy_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               acc_d      = dvd_mag;
               prem_d     = '0;
               dvs_mag_d  = dvs_mag;
               neg_dvd_d  = dividend[DIVIDEND_W-1];
               neg_quo_d  = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
               dvs_zero_d = (divisor == '0);
               ovf_d      = (dividend == SAT_MIN) && (divisor == '1);
               dvd_low_d  = DIVISOR_W'(dividend);
               cnt_d      = CW'(DIVIDEND_W - 1);
               busy_d     = 1'b1;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            // acc doubles as dividend shift-out and quotient shift-in register.
            prem_d = step_rem;
            acc_d  = {acc_q[DIVIDEND_W-2:0], step_q};
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_FIX: begin
            if (dvs_zero_q) begin
               res_quo_d = neg_dvd_q ? SAT_MIN : SAT_MAX;
               res_rem_d = dvd_low_q;
            end else if (ovf_q) begin
               res_quo_d = SAT_MAX;
               res_rem_d = '0;
            end else begin
               res_quo_d = quo_sgn;
               res_rem_d = DIVISOR_W'(rem_sgn);
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            quotient_d  = res_quo_q;
            remainder_d = res_rem_q;
            rdy_d       = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         prem_q      <= '0;
         dvs_mag_q   <= '0;
         neg_dvd_q   <= 1'b0;
         neg_quo_q   <= 1'b0;
         dvs_zero_q  <= 1'b0;
         ovf_q       <= 1'b0;
         dvd_low_q   <= '0;
         res_quo_q   <= '0;
         res_rem_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         prem_q      <= prem_d;
         dvs_mag_q   <= dvs_mag_d;
         neg_dvd_q   <= neg_dvd_d;
         neg_quo_q   <= neg_quo_d;
         dvs_zero_q  <= dvs_zero_d;
         ovf_q       <= ovf_d;
         dvd_low_q   <= dvd_low_d;
         res_quo_q   <= res_quo_d;
         res_rem_q   <= res_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         rdy_q       <= rdy_d;
      end
   end

   assign quotient   = quotient_q;
   assign remainder  = remainder_q;
   assign busy       = busy_q;
   assign result_rdy = rdy_q;

`ifdef SEQ_DIV_ZERO_FLAG_EN
   // Exception flags stay stable until the next accept, which cannot occur
   // before DONE, so they can be sampled directly here.
   logic div_zero_q, div_zero_d;

   always_comb begin
      div_zero_d = div_zero_q;
      if (state_q == ST_DONE) begin
         div_zero_d = dvs_zero_q | ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_zero_q <= 1'b0;
      end else begin
         div_zero_q <= div_zero_d;
      end
   end

   assign div_zero = div_zero_q;
`endif

endmodule
